pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory wait/timeout.
// Optional performance counters (StallCycles, FlushCount) are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL  = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IdExMemRead,
    input  logic [2:0]  IdExTReg,
    input  logic [2:0]  IfIdRs,
    input  logic [2:0]  IfIdRt,
    input  logic        IfIdUsesRt,
    input  logic        ExMemBranch,
    input  logic        ExMemZero,
    input  logic        ExMemMemAccess,
    input  logic        MemReady,
    output logic        PcWrite,
    output logic        IfIdWrite,
    output logic        IdExWrite,
    output logic        ExMemWrite,
    output logic        IfIdFlush,
    output logic        IdExFlush,
    output logic        ExMemFlush,
    output logic        PcSrc,
    output logic        MemTimeout,
    output logic [1:0]  State
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        ERROR   = 2'd3
    } state_e;

    localparam logic [1:0] STALL_INIT   = 2'(LOAD_STALL - 1);
    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);
    localparam bit         MULTI_STALL  = (LOAD_STALL > 1);

    state_e     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic memwait, taken, loaduse;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush, pc_src;

    assign memwait = ExMemMemAccess & ~MemReady;
    assign taken   = ExMemBranch & ExMemZero;
    assign loaduse = IdExMemRead & (IdExTReg != 3'd0) &
                     ((IdExTReg == IfIdRs) | (IfIdUsesRt & (IdExTReg == IfIdRt)));

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;

        unique case (state_q)
            RUN, LDSTALL: begin
                if (memwait) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    state_d     = MEMWAIT;
                    wait_cnt_d  = 4'd0;
                    stall_cnt_d = 2'd0;
                end else if (taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    pc_src      = 1'b1;
                    state_d     = RUN;
                    stall_cnt_d = 2'd0;
                end else if (state_q == LDSTALL) begin
                    // Remaining stall cycles run out regardless of the current loaduse condition.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_flush  = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    if (stall_cnt_q <= 2'd1) begin
                        state_d     = RUN;
                        stall_cnt_d = 2'd0;
                    end
                end else if (loaduse) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (MULTI_STALL) begin
                        state_d     = LDSTALL;
                        stall_cnt_d = STALL_INIT;
                    end
                end
            end
            MEMWAIT: begin
                if (MemReady) begin
                    state_d    = RUN;
                    wait_cnt_d = 4'd0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    if (wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                    if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    // Reset forces every stage enabled and flushed so the pipeline refills with bubbles.
    always_comb begin
        PcWrite    = Rst | pc_write;
        IfIdWrite  = Rst | ifid_write;
        IdExWrite  = Rst | idex_write;
        ExMemWrite = Rst | exmem_write;
        IfIdFlush  = Rst | ifid_flush;
        IdExFlush  = Rst | idex_flush;
        ExMemFlush = Rst | exmem_flush;
        PcSrc      = ~Rst & pc_src;
        MemTimeout = ~Rst & timeout_q;
        State      = state_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 2'd0;
            wait_cnt_q  <= 4'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (!pc_write && stall_cycles_q != 16'hFFFF) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (pc_src && flush_count_q != 16'hFFFF) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (LOAD_STALL=1/MEM_TIMEOUT=15 and
// LOAD_STALL=3/MEM_TIMEOUT=4) share inputs; expected output vectors are queued and checked each cycle.
module tb_pipeline_hazard_ctrl;
  // Output vector layout: {PcWrite,IfIdWrite,IdExWrite,ExMemWrite,IfIdFlush,IdExFlush,ExMemFlush,PcSrc}
  localparam logic [7:0] O_IDLE = 8'b1111_000_0;
  localparam logic [7:0] O_FRZ  = 8'b0000_000_0;
  localparam logic [7:0] O_TKN  = 8'b1111_111_1;
  localparam logic [7:0] O_LDU  = 8'b0011_010_0;
  localparam logic [7:0] O_RST  = 8'b1111_111_0;

  logic       clk;
  logic       rst;
  logic       id_ex_mem_read;
  logic [2:0] id_ex_t_reg, if_id_rs, if_id_rt;
  logic       if_id_uses_rt, ex_mem_branch, ex_mem_zero, ex_mem_mem_access, mem_ready;

  logic       pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a;
  logic       if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, pc_src_a, mem_timeout_a;
  logic [1:0] state_a;
  logic       pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b;
  logic       if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, pc_src_b, mem_timeout_b;
  logic [1:0] state_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_a, flush_count_a, stall_cycles_b, flush_count_b;
`endif

  logic [10:0] exp_a_q[$];
  logic [10:0] exp_b_q[$];
  int n_pass = 0;
  int n_total = 0;

  pipeline_hazard_ctrl #(.LOAD_STALL(1), .MEM_TIMEOUT(15)) u_dut_a (
    .Clk(clk), .Rst(rst),
    .IdExMemRead(id_ex_mem_read), .IdExTReg(id_ex_t_reg), .IfIdRs(if_id_rs), .IfIdRt(if_id_rt),
    .IfIdUsesRt(if_id_uses_rt), .ExMemBranch(ex_mem_branch), .ExMemZero(ex_mem_zero),
    .ExMemMemAccess(ex_mem_mem_access), .MemReady(mem_ready),
    .PcWrite(pc_write_a), .IfIdWrite(if_id_write_a), .IdExWrite(id_ex_write_a),
    .ExMemWrite(ex_mem_write_a), .IfIdFlush(if_id_flush_a), .IdExFlush(id_ex_flush_a),
    .ExMemFlush(ex_mem_flush_a), .PcSrc(pc_src_a), .MemTimeout(mem_timeout_a), .State(state_a)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(stall_cycles_a), .FlushCount(flush_count_a)
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_STALL(3), .MEM_TIMEOUT(4)) u_dut_b (
    .Clk(clk), .Rst(rst),
    .IdExMemRead(id_ex_mem_read), .IdExTReg(id_ex_t_reg), .IfIdRs(if_id_rs), .IfIdRt(if_id_rt),
    .IfIdUsesRt(if_id_uses_rt), .ExMemBranch(ex_mem_branch), .ExMemZero(ex_mem_zero),
    .ExMemMemAccess(ex_mem_mem_access), .MemReady(mem_ready),
    .PcWrite(pc_write_b), .IfIdWrite(if_id_write_b), .IdExWrite(id_ex_write_b),
    .ExMemWrite(ex_mem_write_b), .IfIdFlush(if_id_flush_b), .IdExFlush(id_ex_flush_b),
    .ExMemFlush(ex_mem_flush_b), .PcSrc(pc_src_b), .MemTimeout(mem_timeout_b), .State(state_b)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(stall_cycles_b), .FlushCount(flush_count_b)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] pk(input logic [7:0] o, input logic mt, input logic [1:0] st);
    return {o, mt, st};
  endfunction

  task automatic drive(input logic r, input logic mr, input logic [2:0] tr, input logic [2:0] rs,
                       input logic [2:0] rt, input logic ur, input logic br, input logic z,
                       input logic ma, input logic rdy);
    rst = r; id_ex_mem_read = mr; id_ex_t_reg = tr; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = ur; ex_mem_branch = br; ex_mem_zero = z; ex_mem_mem_access = ma; mem_ready = rdy;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Queue expectations, compare at the falling edge, then move to just after the next rising edge.
  task automatic step(input logic [10:0] ea, input logic [10:0] eb, input string tag);
    logic [10:0] got, e;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    @(negedge clk);
    got = {pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a, if_id_flush_a,
           id_ex_flush_a, ex_mem_flush_a, pc_src_a, mem_timeout_a, state_a};
    e = exp_a_q.pop_front();
    n_total++;
    assert (got === e) n_pass++;
    else $error("FAIL %s/a got=%b exp=%b", tag, got, e);
    got = {pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b, if_id_flush_b,
           id_ex_flush_b, ex_mem_flush_b, pc_src_b, mem_timeout_b, state_b};
    e = exp_b_q.pop_front();
    n_total++;
    assert (got === e) n_pass++;
    else $error("FAIL %s/b got=%b exp=%b", tag, got, e);
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic check16(input logic [15:0] got, input logic [15:0] e, input string tag);
    n_total++;
    assert (got === e) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, e);
  endtask
`endif

  task automatic do_reset(input string tag);
    drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b0);
    step(pk(O_RST, 1'b0, 2'd0), pk(O_RST, 1'b0, 2'd0), tag);
    drive_idle();
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    do_reset("reset");
`ifdef HAZARD_PERF_CNT_EN
    check16(stall_cycles_a, 16'd0, "perf_stall_rst");
    check16(flush_count_b, 16'd0, "perf_flush_rst");
`endif
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "idle");

    // load-use on Rs: one stall cycle for a, three for b
    drive(1'b0, 1'b1, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(pk(O_LDU, 1'b0, 2'd0), pk(O_LDU, 1'b0, 2'd0), "ldu_rs");
    drive_idle();
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_LDU, 1'b0, 2'd1), "ldstall_1");
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_LDU, 1'b0, 2'd1), "ldstall_2");
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "ldstall_done");
`ifdef HAZARD_PERF_CNT_EN
    check16(stall_cycles_a, 16'd1, "perf_stall_a");
    check16(stall_cycles_b, 16'd3, "perf_stall_b");
`endif

    // Rt match only counts when IF/ID reads Rt; then a taken branch aborts b's stall
    do_reset("reset_rt");
    drive(1'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "rt_unused");
    drive(1'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(pk(O_LDU, 1'b0, 2'd0), pk(O_LDU, 1'b0, 2'd0), "ldu_rt");
    drive(1'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(pk(O_TKN, 1'b0, 2'd0), pk(O_TKN, 1'b0, 2'd1), "taken_in_ldstall");
    drive_idle();
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "after_taken");
`ifdef HAZARD_PERF_CNT_EN
    check16(flush_count_a, 16'd1, "perf_flush_a");
    check16(flush_count_b, 16'd1, "perf_flush_b");
`endif

    // register 0 never stalls; branch without Zero is not taken
    do_reset("reset_r0");
    drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "r0_no_stall");
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "branch_not_taken");

    // memwait beats taken and loaduse; MemReady on the timeout cycle of b wins
    do_reset("reset_mw");
    drive(1'b0, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(pk(O_FRZ, 1'b0, 2'd0), pk(O_FRZ, 1'b0, 2'd0), "memwait_prio");
    for (int k = 0; k < 3; k++) begin
      step(pk(O_FRZ, 1'b0, 2'd2), pk(O_FRZ, 1'b0, 2'd2), "memwait_hold");
    end
    mem_ready = 1'b1;
    step(pk(O_IDLE, 1'b0, 2'd2), pk(O_IDLE, 1'b0, 2'd2), "memready_exit");
    drive_idle();
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "after_memwait");

    // MemReady held low: b times out after 4 MEMWAIT cycles, a after 15
    do_reset("reset_to");
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(pk(O_FRZ, 1'b0, 2'd0), pk(O_FRZ, 1'b0, 2'd0), "to_enter");
    for (int k = 0; k < 15; k++) begin
      step(pk(O_FRZ, 1'b0, 2'd2), (k < 4) ? pk(O_FRZ, 1'b0, 2'd2) : pk(O_FRZ, 1'b1, 2'd3),
           "to_wait");
    end
    step(pk(O_FRZ, 1'b1, 2'd3), pk(O_FRZ, 1'b1, 2'd3), "to_error");
    drive(1'b0, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(pk(O_FRZ, 1'b1, 2'd3), pk(O_FRZ, 1'b1, 2'd3), "error_sticky");
    step(pk(O_FRZ, 1'b1, 2'd3), pk(O_FRZ, 1'b1, 2'd3), "error_sticky2");
    rst = 1'b1;
    step(pk(O_RST, 1'b0, 2'd3), pk(O_RST, 1'b0, 2'd3), "rst_in_error");
    drive_idle();
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "error_cleared");

    // reset overrides an in-progress LDSTALL
    drive(1'b0, 1'b1, 3'd6, 3'd1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(pk(O_LDU, 1'b0, 2'd0), pk(O_LDU, 1'b0, 2'd0), "ldu_pre_rst");
    rst = 1'b1;
    step(pk(O_RST, 1'b0, 2'd0), pk(O_RST, 1'b0, 2'd1), "rst_in_ldstall");
    drive_idle();
    step(pk(O_IDLE, 1'b0, 2'd0), pk(O_IDLE, 1'b0, 2'd0), "ldstall_cleared");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
